multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-issue MIPS integer datapath.
//  Steps each instruction through FETCH/DECODE/EXEC/WB and gates PC, IR and register-file writes.
//  Decodes ADDI/ANDI/ORI/XORI/SLTI and R-type ADD/SUB/AND/OR/XOR/SLT/SLTU using the mips_para.v codes.
//  Drives the ALU and register-file control fields, and counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter instr_cnt
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      level; sampled in IDLE, leaves IDLE when 1
//  stop       in   1      level; sampled in WB, returns to IDLE after current instr when 1
//  imem_rdy   in   1      instruction memory data valid
//  op_i       in   6      opcode from instruction bus, valid when imem_rdy=1
//  funct_i    in   6      funct field from instruction bus, valid when imem_rdy=1
//  pc_en      out  1      PC update strobe
//  ir_en      out  1      instruction register load strobe
//  reg_write  out  1      register-file write strobe
//  alu_op     out  4      ALU operation (`alu_add/`alu_sub/`alu_and/`alu_or/`alu_xor/`alu_slt/`alu_sltu)
//  alu_srcb   out  1      1 = immediate, 0 = rt
//  reg_dst    out  1      1 = rd, 0 = rt
//  busy       out  1      1 in any state except IDLE/HALT
//  halt       out  1      1 in HALT (only reachable with ILLEGAL_TRAP_EN)
//  instr_cnt  out  CNT_W  retired-instruction count
//  state_o    out  3      IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5
// BEHAVIOUR
//  - Reset (async, any state, mid-instruction included):
//    state=IDLE; all strobes 0; alu_op=4'b0000; alu_srcb=0; reg_dst=0; busy=0; halt=0; instr_cnt=0.
//  - IDLE: start=1 -> FETCH, else stay.
//  - FETCH: wait while imem_rdy=0 (no strobes).
//    On imem_rdy=1: ir_en=1 that same cycle, capture op_i/funct_i into internal regs -> DECODE.
//  - DECODE: decode captured fields. All control outputs are registered.
//    Legal instr -> EXEC; unsupported op/funct -> see CONFIGURATION.
//  - EXEC: alu_op/alu_srcb/reg_dst valid. They hold through WB.
//    Values per instruction:
//      I-type: srcb=1, dst=0
//      R-type: srcb=0, dst=1
//    -> WB.
//  - WB (exactly 1 cycle): reg_write=1, pc_en=1, instr_cnt+=1 (wraps mod 2^CNT_W).
//    stop=1 -> IDLE, else -> FETCH.
//  - Legal-instruction latency: 4 cycles when imem_rdy is already high; each imem_rdy=0 cycle adds 1.
//  - Strobes: each is asserted for exactly 1 cycle per instruction. reg_write is never asserted outside WB.
//  - Outside EXEC/WB: alu_op=0, alu_srcb=0, reg_dst=0. No X is ever driven.
//  - start and stop both 1: start is only sampled in IDLE and stop only in WB. No conflict.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    - Unsupported instruction in DECODE -> HALT. halt=1, busy=0, all strobes 0.
//    - HALT is left only by rst; start is ignored. instr_cnt is not incremented.
//  ILLEGAL_TRAP_EN undefined:
//    - Unsupported instruction executes as NOP: DECODE -> WB with reg_write=0, pc_en=1.
//    - instr_cnt is not incremented. Flow then continues as normal WB. HALT is unreachable; halt is tied 0.
// TESTING
//  1. rst=1 then 0, start=0 for 5 cycles -> state_o=0, busy=0, instr_cnt=0, all strobes 0.
//  2. start=1, imem_rdy=1, op=6'h08 (ADDI):
//       -> ir_en in cycle 1; alu_op=`alu_add, srcb=1, dst=0 in EXEC;
//       -> reg_write=pc_en=1 in cycle 4; instr_cnt=1.
//  3. op=0, funct=6'h2b (SLTU) with imem_rdy low for 3 cycles in FETCH
//       -> 7-cycle instr; alu_op=`alu_sltu, srcb=0, dst=1.
//  4. op=0, funct=6'h08:
//       -> trap build: state_o=5, halt=1, start ignored until rst.
//       -> no-trap build: pc_en=1, reg_write=0, instr_cnt unchanged.
//  5. CNT_W=4, run 16 ADDI -> instr_cnt wraps to 0.
//     stop=1 during the 16th WB -> IDLE, busy=0.
//  6. Assert rst in EXEC of an OR -> immediate IDLE, reg_write never pulses, instr_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the multi-cycle sequencer and its datapath/imem.
// Latency: none, wires only.
// Backpressure: imem_rdy low holds the sequencer in FETCH; no other stall source.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             stop;
    logic             imem_rdy;
    logic [5:0]       op_i;
    logic [5:0]       funct_i;
    logic             pc_en;
    logic             ir_en;
    logic             reg_write;
    logic [3:0]       alu_op;
    logic             alu_srcb;
    logic             reg_dst;
    logic             busy;
    logic             halt;
    logic [CNT_W-1:0] instr_cnt;
    logic [2:0]       state_o;

    // Environment side: drives control inputs and the instruction bus.
    modport master (
        output start, stop, imem_rdy, op_i, funct_i,
        input  pc_en, ir_en, reg_write, alu_op, alu_srcb, reg_dst,
               busy, halt, instr_cnt, state_o
    );

    // Sequencer side.
    modport slave (
        input  start, stop, imem_rdy, op_i, funct_i,
        output pc_en, ir_en, reg_write, alu_op, alu_srcb, reg_dst,
               busy, halt, instr_cnt, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MIPS integer datapath; decodes ALU ops, counts retirements.
// Latency: 4 cycles per legal instruction with imem_rdy high, +1 per imem_rdy-low FETCH cycle.
// Backpressure: waits in FETCH while imem_rdy=0. Optional macro ILLEGAL_TRAP_EN: unsupported instr -> HALT.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              rst,
    multicycle_ctrl_if.slave bus
);
    // ALU operation codes (0 means "no operation selected").
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;

    // Opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;

    // R-type funct codes.
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q;
    logic [5:0]       op_q;
    logic [5:0]       funct_q;
    logic             pc_en_q;
    logic             reg_write_q;
    logic [3:0]       alu_op_q;
    logic             alu_srcb_q;
    logic             reg_dst_q;
    logic [CNT_W-1:0] cnt_q;

    logic             dec_legal_d;
    logic             dec_itype_d;
    logic [3:0]       dec_alu_d;

    // Decode the captured instruction fields into ALU op and operand routing.
    always_comb begin
        dec_legal_d = 1'b1;
        dec_itype_d = 1'b1;
        dec_alu_d   = ALU_NONE;
        case (op_q)
            OP_RTYPE: begin
                dec_itype_d = 1'b0;
                case (funct_q)
                    FN_ADD:  dec_alu_d = ALU_ADD;
                    FN_SUB:  dec_alu_d = ALU_SUB;
                    FN_AND:  dec_alu_d = ALU_AND;
                    FN_OR:   dec_alu_d = ALU_OR;
                    FN_XOR:  dec_alu_d = ALU_XOR;
                    FN_SLT:  dec_alu_d = ALU_SLT;
                    FN_SLTU: dec_alu_d = ALU_SLTU;
                    default: dec_legal_d = 1'b0;
                endcase
            end
            OP_ADDI: dec_alu_d = ALU_ADD;
            OP_SLTI: dec_alu_d = ALU_SLT;
            OP_ANDI: dec_alu_d = ALU_AND;
            OP_ORI:  dec_alu_d = ALU_OR;
            OP_XORI: dec_alu_d = ALU_XOR;
            default: dec_legal_d = 1'b0;
        endcase
    end

    // Sequencer FSM with registered control outputs; strobes default low so each pulses one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 6'd0;
            funct_q     <= 6'd0;
            pc_en_q     <= 1'b0;
            reg_write_q <= 1'b0;
            alu_op_q    <= ALU_NONE;
            alu_srcb_q  <= 1'b0;
            reg_dst_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pc_en_q     <= 1'b0;
            reg_write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_rdy) begin
                        op_q    <= bus.op_i;
                        funct_q <= bus.funct_i;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_legal_d) begin
                        alu_op_q   <= dec_alu_d;
                        alu_srcb_q <= dec_itype_d;
                        reg_dst_q  <= ~dec_itype_d;
                        state_q    <= S_EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_q <= S_HALT;
`else
                        // Unsupported instruction retires as a NOP: advance PC, no write.
                        pc_en_q <= 1'b1;
                        state_q <= S_WB;
`endif
                    end
                end
                S_EXEC: begin
                    reg_write_q <= 1'b1;
                    pc_en_q     <= 1'b1;
                    state_q     <= S_WB;
                end
                S_WB: begin
                    // reg_write_q high in WB marks a legal retirement; NOPs are not counted.
                    if (reg_write_q) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                    alu_op_q   <= ALU_NONE;
                    alu_srcb_q <= 1'b0;
                    reg_dst_q  <= 1'b0;
                    state_q    <= bus.stop ? S_IDLE : S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ir_en must fire in the same cycle imem_rdy arrives, so it is decoded from the state register.
    assign bus.ir_en     = (state_q == S_FETCH) && bus.imem_rdy;
    assign bus.pc_en     = pc_en_q;
    assign bus.reg_write = reg_write_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_srcb  = alu_srcb_q;
    assign bus.reg_dst   = reg_dst_q;
    assign bus.instr_cnt = cnt_q;
    assign bus.state_o   = state_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_HALT);
`ifdef ILLEGAL_TRAP_EN
    assign bus.halt      = (state_q == S_HALT);
`else
    assign bus.halt      = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: scoreboard of expected per-instruction results.
// Latency: checks instruction latency FETCH..WB per instruction.
// Backpressure: imem_rdy held low for a chosen number of FETCH cycles.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    localparam int CW = 4;

    localparam logic [3:0] A_ADD  = 4'd1;
    localparam logic [3:0] A_SUB  = 4'd2;
    localparam logic [3:0] A_AND  = 4'd3;
    localparam logic [3:0] A_OR   = 4'd4;
    localparam logic [3:0] A_XOR  = 4'd5;
    localparam logic [3:0] A_SLT  = 4'd6;
    localparam logic [3:0] A_SLTU = 4'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] alu;
        logic       srcb;
        logic       dst;
        logic       legal;
        int         lat;
    } exp_t;

    exp_t sb[$];

    // Reference decode model.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input int stall);
        exp_t e;
        e.alu = 4'd0; e.srcb = 1'b0; e.dst = 1'b0; e.legal = 1'b1; e.lat = 4 + stall;
        if (op == 6'h00) begin
            e.dst = 1'b1;
            case (fn)
                6'h20: e.alu = A_ADD;
                6'h22: e.alu = A_SUB;
                6'h24: e.alu = A_AND;
                6'h25: e.alu = A_OR;
                6'h26: e.alu = A_XOR;
                6'h2a: e.alu = A_SLT;
                6'h2b: e.alu = A_SLTU;
                default: e.legal = 1'b0;
            endcase
        end else begin
            e.srcb = 1'b1;
            case (op)
                6'h08: e.alu = A_ADD;
                6'h0a: e.alu = A_SLT;
                6'h0c: e.alu = A_AND;
                6'h0d: e.alu = A_OR;
                6'h0e: e.alu = A_XOR;
                default: e.legal = 1'b0;
            endcase
        end
        if (!e.legal) begin
            e.alu = 4'd0; e.srcb = 1'b0; e.dst = 1'b0; e.lat = 3 + stall;
        end
        return e;
    endfunction

    // Monitor: per-cycle invariants plus scoreboard comparison at every WB.
    bit         mon_in = 1'b0;
    int         mon_cyc = 0;
    int         mon_ir = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [3:0] ex_alu = 4'd0;
    logic       ex_srcb = 1'b0;
    logic       ex_dst = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            mon_in = 1'b0; mon_cyc = 0; mon_ir = 0; exp_cnt = '0;
            sb.delete();
        end else begin
            if (bus.state_o == 3'd1 && !mon_in) begin
                mon_in = 1'b1; mon_cyc = 0; mon_ir = 0;
            end
            if (mon_in) begin
                mon_cyc++;
                if (bus.ir_en) mon_ir++;
            end
            checks++;
            if (bus.state_o != 3'd4 && (bus.reg_write !== 1'b0 || bus.pc_en !== 1'b0)) begin
                errors++;
                $display("FAIL strobe_outside_wb state=%0d reg_write=%b pc_en=%b want 0/0", bus.state_o, bus.reg_write, bus.pc_en);
            end
            if (bus.state_o != 3'd3 && bus.state_o != 3'd4) begin
                checks++;
                if (bus.alu_op !== 4'd0 || bus.alu_srcb !== 1'b0 || bus.reg_dst !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_idle state=%0d alu_op=%0d srcb=%b dst=%b want 0/0/0", bus.state_o, bus.alu_op, bus.alu_srcb, bus.reg_dst);
                end
            end
            if (bus.state_o == 3'd3) begin
                ex_alu = bus.alu_op; ex_srcb = bus.alu_srcb; ex_dst = bus.reg_dst;
            end
            if (bus.state_o == 3'd4) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty unexpected WB got 1 want 0");
                end else begin
                    e = sb.pop_front();
                    if (mon_cyc !== e.lat) begin
                        errors++;
                        $display("FAIL latency got %0d want %0d", mon_cyc, e.lat);
                    end
                    checks++;
                    if (bus.reg_write !== e.legal || bus.pc_en !== 1'b1) begin
                        errors++;
                        $display("FAIL wb_strobes reg_write=%b pc_en=%b want %b/1", bus.reg_write, bus.pc_en, e.legal);
                    end
                    checks++;
                    if (mon_ir !== 1) begin
                        errors++;
                        $display("FAIL ir_en_pulses got %0d want 1", mon_ir);
                    end
                    checks++;
                    if (bus.instr_cnt !== exp_cnt) begin
                        errors++;
                        $display("FAIL wb_count got %0d want %0d", bus.instr_cnt, exp_cnt);
                    end
                    checks++;
                    if (bus.alu_op !== e.alu || bus.alu_srcb !== e.srcb || bus.reg_dst !== e.dst) begin
                        errors++;
                        $display("FAIL wb_alu got %0d/%b/%b want %0d/%b/%b", bus.alu_op, bus.alu_srcb, bus.reg_dst, e.alu, e.srcb, e.dst);
                    end
                    if (e.legal) begin
                        checks++;
                        if (ex_alu !== e.alu || ex_srcb !== e.srcb || ex_dst !== e.dst) begin
                            errors++;
                            $display("FAIL exec_alu got %0d/%b/%b want %0d/%b/%b", ex_alu, ex_srcb, ex_dst, e.alu, e.srcb, e.dst);
                        end
                        exp_cnt = exp_cnt + 1'b1;
                    end
                end
                mon_in = 1'b0;
            end
        end
    end

    // Stimulus driver: pushes the expectation, then runs one instruction through to WB.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int stall, input bit last);
        int t;
        sb.push_back(model(op, fn, stall));
        bus.op_i = op;
        bus.funct_i = fn;
        bus.imem_rdy = (stall == 0);
        t = 0;
        while (bus.state_o != 3'd1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (bus.state_o != 3'd1) begin
            checks++; errors++;
            $display("FAIL fetch_timeout state=%0d want 1", bus.state_o);
            return;
        end
        bus.start = 1'b0;
        bus.stop = last;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            bus.imem_rdy = 1'b1;
        end
        t = 0;
        while (bus.state_o != 3'd4 && t < 12) begin
            @(negedge clk);
            t++;
        end
        if (bus.state_o != 3'd4) begin
            checks++; errors++;
            $display("FAIL wb_timeout state=%0d want 4", bus.state_o);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.stop = 1'b0; bus.imem_rdy = 1'b0;
        bus.op_i = 6'd0; bus.funct_i = 6'd0;
        pulse_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (bus.state_o !== 3'd0 || bus.busy !== 1'b0 || bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_state state=%0d busy=%b halt=%b want 0/0/0", bus.state_o, bus.busy, bus.halt);
        end
        checks++;
        if (bus.instr_cnt !== '0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", bus.instr_cnt);
        end
        checks++;
        if (bus.pc_en !== 1'b0 || bus.ir_en !== 1'b0 || bus.reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes pc_en=%b ir_en=%b reg_write=%b want 0", bus.pc_en, bus.ir_en, bus.reg_write);
        end
        checks++;
        if (bus.alu_op !== 4'd0 || bus.alu_srcb !== 1'b0 || bus.reg_dst !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu got %0d/%b/%b want 0/0/0", bus.alu_op, bus.alu_srcb, bus.reg_dst);
        end
    endtask

    task automatic test_addi();
        bus.start = 1'b1;
        issue(6'h08, 6'h00, 0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_cnt !== 4'd1 || bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL addi_done cnt=%0d state=%0d busy=%b want 1/0/0", bus.instr_cnt, bus.state_o, bus.busy);
        end
    endtask

    task automatic test_sltu_stall();
        bus.start = 1'b1;
        issue(6'h00, 6'h2b, 3, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_cnt !== 4'd2) begin
            errors++;
            $display("FAIL sltu_count got %0d want 2", bus.instr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [12];
        logic [5:0] fns [12];
        ops = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        fns = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b};
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], fns[i], int'($urandom_range(0, 2)), i == 11);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_cnt !== 4'd14 || bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL b2b_done cnt=%0d state=%0d want 14/0", bus.instr_cnt, bus.state_o);
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
        int t;
        bus.start = 1'b1;
        bus.op_i = 6'h00; bus.funct_i = 6'h08; bus.imem_rdy = 1'b1;
        t = 0;
        while (bus.state_o != 3'd5 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.state_o !== 3'd5 || bus.halt !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL trap_halt state=%0d halt=%b busy=%b want 5/1/0", bus.state_o, bus.halt, bus.busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.state_o !== 3'd5 || bus.pc_en !== 1'b0 || bus.ir_en !== 1'b0 || bus.reg_write !== 1'b0) begin
            errors++;
            $display("FAIL trap_sticky state=%0d strobes=%b%b%b want 5/000", bus.state_o, bus.pc_en, bus.ir_en, bus.reg_write);
        end
        checks++;
        if (bus.instr_cnt !== 4'd14) begin
            errors++;
            $display("FAIL trap_count got %0d want 14", bus.instr_cnt);
        end
        pulse_reset();
        @(negedge clk);
        checks++;
        if (bus.state_o !== 3'd0 || bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL trap_exit state=%0d halt=%b want 0/0", bus.state_o, bus.halt);
        end
`else
        bus.start = 1'b1;
        issue(6'h00, 6'h08, 0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_cnt !== 4'd14 || bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL nop_count cnt=%0d halt=%b want 14/0", bus.instr_cnt, bus.halt);
        end
        bus.start = 1'b1;
        issue(6'h23, 6'h00, 1, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_cnt !== 4'd14 || bus.state_o !== 3'd0) begin
            errors++;
            $display("FAIL nop_op_count cnt=%0d state=%0d want 14/0", bus.instr_cnt, bus.state_o);
        end
`endif
    endtask

    task automatic test_wrap();
        pulse_reset();
        bus.start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(6'h08, 6'h00, 0, i == 15);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_cnt !== 4'd0 || bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap cnt=%0d state=%0d busy=%b want 0/0/0", bus.instr_cnt, bus.state_o, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        bus.start = 1'b1;
        issue(6'h0d, 6'h00, 0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_cnt !== 4'd1) begin
            errors++;
            $display("FAIL pre_rst_count got %0d want 1", bus.instr_cnt);
        end
        bus.start = 1'b1;
        bus.op_i = 6'h00; bus.funct_i = 6'h25; bus.imem_rdy = 1'b1; bus.stop = 1'b0;
        t = 0;
        while (bus.state_o != 3'd3 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.state_o !== 3'd3) begin
            errors++;
            $display("FAIL exec_reach state=%0d want 3", bus.state_o);
        end
        rst = 1'b1;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.state_o !== 3'd0 || bus.busy !== 1'b0 || bus.reg_write !== 1'b0 || bus.instr_cnt !== 4'd0 || bus.alu_op !== 4'd0) begin
            errors++;
            $display("FAIL async_rst state=%0d busy=%b reg_write=%b cnt=%0d alu=%0d want 0/0/0/0/0",
                     bus.state_o, bus.busy, bus.reg_write, bus.instr_cnt, bus.alu_op);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.state_o !== 3'd0 || bus.instr_cnt !== 4'd0) begin
            errors++;
            $display("FAIL post_rst state=%0d cnt=%0d want 0/0", bus.state_o, bus.instr_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_sltu_stall();
        test_back_to_back();
        test_illegal();
        test_wrap();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
